// File: rtl/cnn_pkg.sv
// Shared types for the CNN pooling/packing datapath.
package cnn_pkg;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] data_t;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} pack_state_t;
endpackage

// File: rtl/cnn_max_window.sv
// Running max over POOL_SIZE accepted samples; win_max is the window result including the current sample.
module cnn_max_window
  import cnn_pkg::*;
#(
  parameter int POOL_SIZE = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  s_valid,
  input  data_t s,
  input  logic  clr,
  output logic  win_done,
  output data_t win_max
);
  localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0] r_win_cnt;
  data_t            r_max_acc;

  // Strict compare so a tie keeps the value already held.
  function automatic data_t max_keep(data_t acc, data_t x);
    return (x > acc) ? x : acc;
  endfunction

  always_comb begin
    win_max  = (r_win_cnt == '0) ? s : max_keep(r_max_acc, s);
    win_done = s_valid && (r_win_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_win_cnt <= '0;
      r_max_acc <= '0;
    end else if (s_valid) begin
      r_win_cnt <= win_done ? '0 : r_win_cnt + 1'b1;
      r_max_acc <= win_max;
    end
  end
endmodule

// File: rtl/cnn_pool_packer.sv
// ReLU + 1-D max pool a conv sample stream and pack NUM_INPUTS results into a vector held until fc_ack.
module cnn_pool_packer
  import cnn_pkg::*;
#(
  parameter int NUM_INPUTS = 24,
  parameter int POOL_SIZE  = 2,
  parameter int RELU_EN    = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  data_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  input  logic  fc_ack,
  output data_t pool_result [NUM_INPUTS],
  output logic  Done
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  pack_state_t      r_state, w_state_nxt;
  logic             r_in_ready, r_done;
  logic             w_ready_nxt, w_done_nxt;
  logic [IDX_W-1:0] r_out_idx;
  data_t            r_pool [NUM_INPUTS];
  logic             w_accept, w_win_done, w_frame_end;
  data_t            w_s, w_win_max;

  function automatic data_t relu(data_t x);
    return ((RELU_EN != 0) && (x < 0)) ? '0 : x;
  endfunction

  assign w_accept    = in_valid && r_in_ready;
  assign w_s         = relu(in_data);
  assign w_frame_end = w_win_done && (r_out_idx == LAST_IDX);

  cnn_max_window #(.POOL_SIZE(POOL_SIZE)) u_win (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (w_accept),
    .s        (w_s),
    .clr      (r_state == HOLD),
    .win_done (w_win_done),
    .win_max  (w_win_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_ready_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_frame_end) w_state_nxt = HOLD;
      HOLD:    if (fc_ack)      w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_comb begin
    w_ready_nxt = (w_state_nxt == FILL);
    w_done_nxt  = (w_state_nxt == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_idx <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) r_pool[i] <= '0;
    end else if (w_win_done) begin
      r_pool[r_out_idx] <= w_win_max;
      r_out_idx         <= w_frame_end ? '0 : r_out_idx + 1'b1;
    end
  end

  assign pool_result = r_pool;
  assign in_ready    = r_in_ready;
  assign Done        = r_done;
endmodule
